// File: rtl/problem_1b.sv
// Two-input truth-table cell: combinational Y, registered Y_q with rising-edge
// pulse, and four saturating hit counters indexed by the {A,B} combination.
module problem_1b #(
  parameter logic [3:0] TRUTH_TABLE = 4'b0110,
  parameter int         CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               A,
  input  logic               B,
  input  logic               clr_cnt,
  output logic               Y,
  output logic               Y_q,
  output logic               Y_rise,
  output logic [4*CNT_W-1:0] hit_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       sel;
  logic [CNT_W-1:0] cnt [4];

  assign sel = {A, B};
  assign Y   = TRUTH_TABLE[sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y_q    <= 1'b0;
      Y_rise <= 1'b0;
    end else begin
      Y_q    <= Y;
      Y_rise <= Y & ~Y_q;
    end
  end

  // Clear outranks the increment, so the clearing cycle's combination is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else if (clr_cnt) begin
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else if (cnt[sel] != CNT_MAX) begin
      cnt[sel] <= cnt[sel] + CNT_W'(1);
    end
  end

  always_comb begin
    hit_cnt = '0;
    for (int k = 0; k < 4; k++) hit_cnt[k*CNT_W +: CNT_W] = cnt[k];
  end

endmodule

// File: tb/tb_problem_1b.sv
// Bench for problem_1b: an XOR cell at CNT_W=8 and an AND cell at CNT_W=2 share
// stimulus; a behavioural model is compared every cycle, plus literal checks.
module tb_problem_1b;

  logic        clk = 1'b0;
  logic        rst_n, A, B, clr_cnt;
  logic        y0, yq0, yr0, y1, yq1, yr1;
  logic [31:0] hit0;
  logic [7:0]  hit1;

  int  n_pass = 0;
  int  n_total = 0;
  bit  check_en = 1'b0;

  int  m_cnt [2][4];
  bit  m_yq [2];
  bit  m_rise [2];
  int  maxc [2] = '{255, 3};
  int  xor_lit [4] = '{0, 1, 1, 0};
  int  and_lit [4] = '{0, 0, 0, 1};

  always #5 clk = ~clk;

  problem_1b u_xor (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .clr_cnt(clr_cnt),
    .Y(y0), .Y_q(yq0), .Y_rise(yr0), .hit_cnt(hit0)
  );

  problem_1b #(.TRUTH_TABLE(4'b1000), .CNT_W(2)) u_and (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .clr_cnt(clr_cnt),
    .Y(y1), .Y_q(yq1), .Y_rise(yr1), .hit_cnt(hit1)
  );

  function automatic int exp_y(input int inst, input bit a, input bit b);
    int tt;
    tt = (inst == 0) ? 6 : 8;
    return (tt >> (2 * a + b)) & 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_yq[i] = 1'b0;
        m_rise[i] = 1'b0;
        for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int y;
        y = exp_y(i, A, B);
        m_rise[i] = (y == 1) && !m_yq[i];
        m_yq[i] = (y == 1);
        if (clr_cnt) begin
          for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
        end else if (m_cnt[i][2 * A + B] < maxc[i]) begin
          m_cnt[i][2 * A + B] = m_cnt[i][2 * A + B] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("xor_y", y0, exp_y(0, A, B));
      chk("xor_yq", yq0, m_yq[0]);
      chk("xor_rise", yr0, m_rise[0]);
      chk("and_y", y1, exp_y(1, A, B));
      chk("and_yq", yq1, m_yq[1]);
      chk("and_rise", yr1, m_rise[1]);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("xor_cnt%0d", k), int'(hit0[k*8 +: 8]), m_cnt[0][k]);
        chk($sformatf("and_cnt%0d", k), int'(hit1[k*2 +: 2]), m_cnt[1][k]);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    A = 1'b0;
    B = 1'b0;
    clr_cnt = 1'b0;
    #1;
    chk("rst_yq", yq0, 0);
    chk("rst_cnt", int'(hit0), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic apply(input bit a, input bit b, input bit c);
    A = a;
    B = b;
    clr_cnt = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    A = 1'b0;
    B = 1'b0;
    clr_cnt = 1'b0;

    // combinational sweep, taken while in reset: Y must still follow inputs
    for (int v = 0; v < 4; v++) begin
      {A, B} = v[1:0];
      #4;
      chk("sweep_xor", y0, xor_lit[v]);
      chk("sweep_and", y1, and_lit[v]);
      #1;
    end

    check_en = 1'b1;

    do_reset();
    apply(0, 0, 0); chk("reg_yq0", yq0, 0); chk("reg_rise0", yr0, 0);
    apply(0, 1, 0); chk("reg_yq1", yq0, 1); chk("reg_rise1", yr0, 1);
    apply(0, 1, 0); chk("reg_yq2", yq0, 1); chk("reg_rise2", yr0, 0);
    apply(1, 1, 0); chk("reg_yq3", yq0, 0); chk("reg_rise3", yr0, 0);

    do_reset();
    repeat (3) apply(0, 1, 0);
    repeat (2) apply(1, 0, 0);
    chk("cnt_s0", int'(hit0[7:0]), 0);
    chk("cnt_s1", int'(hit0[15:8]), 3);
    chk("cnt_s2", int'(hit0[23:16]), 2);
    chk("cnt_s3", int'(hit0[31:24]), 0);

    do_reset();
    repeat (6) apply(1, 1, 0);
    chk("sat_and_s3", int'(hit1[7:6]), 3);
    chk("sat_xor_s3", int'(hit0[31:24]), 6);
    apply(1, 1, 1);
    chk("clr_and", int'(hit1), 0);
    chk("clr_xor", int'(hit0), 0);

    do_reset();
    apply(0, 1, 0);
    apply(0, 1, 0);
    chk("pre_async_yq", yq0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_yq", yq0, 0);
    chk("async_rise", yr0, 0);
    chk("async_cnt", int'(hit0), 0);
    chk("async_y", y0, 1);
    #1;
    rst_n = 1'b1;
    apply(1, 1, 0);
    chk("post_rst_s3", int'(hit0[31:24]), 1);
    chk("post_rst_s1", int'(hit0[15:8]), 0);

    do_reset();
    apply(0, 0, 0); chk("and_yq00", yq1, 0);
    apply(0, 1, 0); chk("and_yq01", yq1, 0);
    apply(1, 0, 0); chk("and_yq10", yq1, 0);
    apply(1, 1, 0); chk("and_yq11", yq1, 1); chk("and_rise11", yr1, 1);
    apply(0, 0, 0); chk("and_yq_back", yq1, 0);

    @(posedge clk);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
